// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store initiator.
//   - RV32 funct3 encodings for loads and stores
//   - FSM state enum
//   - captured-op struct
//   - helpers: byte-enable mask, funct3 legality, alignment check
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

  // Everything the response path needs to remember about the op in flight.
  typedef struct packed {
    logic       is_load;
    logic [2:0] funct3;
    logic [1:0] off;
  } lsu_op_t;

  // Byte enables for a store of the given size at byte offset off.
  // funct3[1:0] carries the size (00 byte, 01 half, 10 word).
  function automatic logic [3:0] byte_mask(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   byte_mask = 4'b0001 << off;
      2'b01:   byte_mask = 4'b0011 << off;
      default: byte_mask = 4'b1111;
    endcase
  endfunction

  // Loads accept LB/LH/LW/LBU/LHU; stores accept only SB/SH/SW.
  function automatic logic f3_illegal(input logic is_store, input logic [2:0] f3);
    if (is_store) f3_illegal = (f3 != F3_SB) && (f3 != F3_SH) && (f3 != F3_SW);
    else          f3_illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b01:   misaligned = off[0];
      2'b10:   misaligned = |off;
      default: misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational byte-lane steering for both directions.
//   funct3, off : op size/sign and byte offset within the word
//   st_data     : LSB-aligned store data  -> wmask / wdata (lane-shifted)
//   ld_word     : full read word          -> ld_data (shifted down, extended)
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_word,
  output logic [3:0]  wmask,
  output logic [31:0] wdata,
  output logic [31:0] ld_data
);

  logic [31:0] ld_sh;

  assign wmask = byte_mask(funct3, off);
  assign wdata = st_data << {off, 3'b000};
  assign ld_sh = ld_word >> {off, 3'b000};

  always_comb begin
    ld_data = ld_sh;
    case (funct3)
      F3_LB:   ld_data = {{24{ld_sh[7]}}, ld_sh[7:0]};
      F3_LH:   ld_data = {{16{ld_sh[15]}}, ld_sh[15:0]};
      F3_LBU:  ld_data = {24'h0, ld_sh[7:0]};
      F3_LHU:  ld_data = {16'h0, ld_sh[15:0]};
      default: ld_data = ld_sh;
    endcase
  end

endmodule

// File: rtl/lsu_mem_initiator.sv
// lsu_mem_initiator: single-outstanding load/store initiator toward the data SRAM.
//   EXU side : in_valid/in_ready, in_is_load, in_is_store, in_funct3, in_addr, in_wdata
//   WBU side : out_valid/out_ready, out_rdata, out_fault
//   Memory   : mem_req_* (valid/ready, we, word addr, wmask, wdata),
//              mem_rsp_* (valid/ready, rdata)
// One op at a time: IDLE -> (REQ -> RSP ->) DONE -> IDLE. Decode faults and
// non-memory ops skip straight to DONE. A response timeout reports a fault and
// leaves drop_pending set so the late reply is swallowed before the next op.
module lsu_mem_initiator
  import lsu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_is_load,
  input  logic              in_is_store,
  input  logic [2:0]        in_funct3,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [31:0]       in_wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_rdata,
  output logic              out_fault,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [3:0]        mem_req_wmask,
  output logic [31:0]       mem_req_wdata,
  input  logic              mem_rsp_valid,
  output logic              mem_rsp_ready,
  input  logic [31:0]       mem_rsp_rdata
);

  localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW:0] TMAX = TIMEOUT[TW:0];

  lsu_state_e  state;
  logic        drop_pending;
  logic [TW-1:0] timer;
  logic [TW:0] timer_nx;
  lsu_op_t     op;

  logic        cap, is_mem, bad;
  logic [2:0]  al_f3;
  logic [1:0]  al_off;
  logic [3:0]  al_wmask;
  logic [31:0] al_wdata, al_ld;

  assign in_ready      = (state == IDLE) && !drop_pending;
  assign out_valid     = (state == DONE);
  assign mem_req_valid = (state == REQ);
  assign mem_rsp_ready = (state == RSP) || drop_pending;

  assign cap    = in_valid && in_ready;
  assign is_mem = in_is_load || in_is_store;
  assign bad    = f3_illegal(in_is_store, in_funct3) || misaligned(in_funct3, in_addr[1:0]);

  // Store steering is only needed at capture (IDLE) and load steering only in
  // RSP, so one aligner serves both by muxing its op fields on state.
  assign al_f3  = (state == IDLE) ? in_funct3    : op.funct3;
  assign al_off = (state == IDLE) ? in_addr[1:0] : op.off;

  lsu_lane_align u_align (
    .funct3  (al_f3),
    .off     (al_off),
    .st_data (in_wdata),
    .ld_word (mem_rsp_rdata),
    .wmask   (al_wmask),
    .wdata   (al_wdata),
    .ld_data (al_ld)
  );

  // timer_nx is one bit wider so the TIMEOUT compare never wraps.
  assign timer_nx = {1'b0, timer} + 1'b1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      drop_pending  <= 1'b0;
      timer         <= '0;
      op            <= '0;
      out_rdata     <= '0;
      out_fault     <= 1'b0;
      mem_req_we    <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wmask <= '0;
      mem_req_wdata <= '0;
    end else begin
      // Set only on leaving RSP, cleared only outside RSP: never both at once.
      if (drop_pending && mem_rsp_valid) drop_pending <= 1'b0;

      case (state)
        IDLE: begin
          if (cap) begin
            op <= '{is_load: in_is_load, funct3: in_funct3, off: in_addr[1:0]};
            if (!is_mem) begin
              state     <= DONE;
              out_rdata <= 32'(in_addr);
              out_fault <= 1'b0;
            end else if (bad) begin
              state     <= DONE;
              out_rdata <= '0;
              out_fault <= 1'b1;
            end else begin
              state         <= REQ;
              mem_req_we    <= in_is_store;
              mem_req_addr  <= {in_addr[ADDR_W-1:2], 2'b00};
              mem_req_wmask <= in_is_store ? al_wmask : 4'b0000;
              mem_req_wdata <= in_is_store ? al_wdata : 32'h0;
            end
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            state <= RSP;
            timer <= '0;
          end
        end
        RSP: begin
          // A reply in the timeout cycle takes priority over the fault.
          if (mem_rsp_valid) begin
            state     <= DONE;
            out_rdata <= op.is_load ? al_ld : 32'h0;
            out_fault <= 1'b0;
          end else if ((TIMEOUT != 0) && (timer_nx == TMAX)) begin
            state        <= DONE;
            out_rdata    <= '0;
            out_fault    <= 1'b1;
            drop_pending <= 1'b1;
          end else begin
            timer <= timer_nx[TW-1:0];
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Self-checking bench for lsu_mem_initiator (TIMEOUT=4): directed ops from the
// test plan, randomized ops against a byte-level reference model, timeout/drop
// handling and asynchronous reset in the middle of a transaction.
module tb_lsu_mem_initiator;

  localparam int TO = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic        in_is_load = 1'b0, in_is_store = 1'b0;
  logic [2:0]  in_funct3 = 3'b0;
  logic [31:0] in_addr = 32'h0, in_wdata = 32'h0;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] out_rdata;
  logic        out_fault;
  logic        mem_req_valid, mem_req_ready = 1'b0, mem_req_we;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_rsp_valid = 1'b0, mem_rsp_ready;
  logic [31:0] mem_rsp_rdata = 32'h0;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  lsu_mem_initiator #(.ADDR_W(32), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_is_load(in_is_load), .in_is_store(in_is_store),
    .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rdata(out_rdata), .out_fault(out_fault),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wmask(mem_req_wmask), .mem_req_wdata(mem_req_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready),
    .mem_rsp_rdata(mem_rsp_rdata)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference: what the op should do, in terms of sizes and byte positions.
  task automatic model(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] mw,
                       output logic mem, output logic [3:0] msk, output logic [31:0] wdo,
                       output logic [31:0] rd, output logic flt);
    int off, size;
    logic [31:0] v;
    off  = int'(a[1:0]);
    size = 1 << int'(f3[1:0]);
    mem = 1'b0; msk = 4'h0; wdo = 32'h0; rd = 32'h0; flt = 1'b0;
    if (!ld && !st) begin
      rd = a;
    end else if ((ld && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) ||
                 (st && f3 > 3'd2) || (off % size != 0)) begin
      flt = 1'b1;
    end else begin
      mem = 1'b1;
      if (st) begin
        msk = 4'(((1 << size) - 1) << off);
        wdo = wd << (8 * off);
      end else begin
        v = 32'h0;
        for (int k = 0; k < size; k++)
          v = v | (((mw >> (8 * (off + k))) & 32'hFF) << (8 * k));
        if (!f3[2] && size < 4 && v[8*size-1])
          v = v | (32'hFFFF_FFFF << (8 * size));
        rd = v;
      end
    end
  endtask

  // Issue one op, play responder with the given stalls, and check every cycle.
  task automatic run_op(input string nm, input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] mw,
                        input int req_st, input int rsp_st, input int out_st);
    logic em, ef;
    logic [3:0] emsk;
    logic [31:0] ewd, erd, wa;
    model(ld, st, f3, a, wd, mw, em, emsk, ewd, erd, ef);
    wa = {a[31:2], 2'b00};
    chk({nm, " in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_is_load = ld; in_is_store = st;
    in_funct3 = f3; in_addr = a; in_wdata = wd;
    tick();
    // Scramble inputs after capture: the DUT must hold its own copy.
    in_valid = 1'b0; in_addr = $urandom; in_wdata = $urandom; in_funct3 = 3'($urandom);
    if (em) begin
      for (int i = 0; i <= req_st; i++) begin
        chk({nm, " req_valid"}, 32'(mem_req_valid), 32'd1);
        chk({nm, " req_we"}, 32'(mem_req_we), 32'(st));
        chk({nm, " req_addr"}, mem_req_addr, wa);
        if (st) begin
          chk({nm, " req_wmask"}, 32'(mem_req_wmask), 32'(emsk));
          chk({nm, " req_wdata"}, mem_req_wdata, ewd);
        end
        mem_req_ready = (i == req_st);
        tick();
      end
      mem_req_ready = 1'b0;
      for (int i = 0; i <= rsp_st; i++) begin
        chk({nm, " rsp_ready"}, 32'(mem_rsp_ready), 32'd1);
        chk({nm, " early out_valid"}, 32'(out_valid), 32'd0);
        mem_rsp_valid = (i == rsp_st);
        mem_rsp_rdata = (i == rsp_st) ? mw : $urandom;
        tick();
      end
      mem_rsp_valid = 1'b0;
    end
    for (int i = 0; i <= out_st; i++) begin
      chk({nm, " out_valid"}, 32'(out_valid), 32'd1);
      chk({nm, " out_rdata"}, out_rdata, erd);
      chk({nm, " out_fault"}, 32'(out_fault), 32'(ef));
      chk({nm, " busy in_ready"}, 32'(in_ready), 32'd0);
      if (!em) chk({nm, " no req"}, 32'(mem_req_valid), 32'd0);
      out_ready = (i == out_st);
      tick();
    end
    out_ready = 1'b0;
    chk({nm, " out_valid drop"}, 32'(out_valid), 32'd0);
    chk({nm, " idle in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out_fault", 32'(out_fault), 32'd0);
    chk("rst out_rdata", out_rdata, 32'd0);
    chk("rst req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst rsp_ready", 32'(mem_rsp_ready), 32'd0);
    chk("rst req_we", 32'(mem_req_we), 32'd0);
    chk("rst req_addr", mem_req_addr, 32'd0);
    chk("rst req_wmask", 32'(mem_req_wmask), 32'd0);
    chk("rst req_wdata", mem_req_wdata, 32'd0);
    tick();
    reset = 1'b1;
    tick();

    // Directed ops
    run_op("sw",   1'b0, 1'b1, 3'b010, 32'h8000_0104, 32'hDEAD_BEEF, 32'h0, 0, 0, 0);
    run_op("sb",   1'b0, 1'b1, 3'b000, 32'h8000_0003, 32'h0000_00A5, 32'h0, 0, 0, 0);
    run_op("lb",   1'b1, 1'b0, 3'b000, 32'h8000_0003, 32'h0, 32'hA511_2233, 0, 0, 0);
    run_op("lbu",  1'b1, 1'b0, 3'b100, 32'h8000_0003, 32'h0, 32'hA511_2233, 0, 0, 0);
    run_op("lh",   1'b1, 1'b0, 3'b001, 32'h8000_0002, 32'h0, 32'h8001_7FFF, 0, 0, 0);
    run_op("lh misaligned", 1'b1, 1'b0, 3'b001, 32'h8000_0001, 32'h0, 32'h0, 0, 0, 1);
    run_op("pass", 1'b0, 1'b0, 3'b000, 32'h1234_5678, 32'h0, 32'h0, 0, 0, 5);
    run_op("sh hi", 1'b0, 1'b1, 3'b001, 32'h0000_0042, 32'h1234_ABCD, 32'h0, 1, 2, 0);
    run_op("st illegal", 1'b0, 1'b1, 3'b100, 32'h0000_0040, 32'h1, 32'h0, 0, 0, 0);
    // Response lands in the same cycle the timeout would fire: data wins.
    run_op("lw stall", 1'b1, 1'b0, 3'b010, 32'h8000_0010, 32'h0, 32'hCAFE_F00D, 7, 3, 2);

    // Reply while IDLE must not be acknowledged
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h5555_AAAA;
    #1;
    chk("idle rsp_ready", 32'(mem_rsp_ready), 32'd0);
    tick();
    chk("idle stray out_valid", 32'(out_valid), 32'd0);
    chk("idle stray in_ready", 32'(in_ready), 32'd1);
    mem_rsp_valid = 1'b0;

    // Timeout: responder stays silent
    in_valid = 1'b1; in_is_load = 1'b1; in_is_store = 1'b0;
    in_funct3 = 3'b010; in_addr = 32'h0000_0100;
    tick();
    in_valid = 1'b0;
    chk("to req_valid", 32'(mem_req_valid), 32'd1);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    for (int i = 0; i < TO; i++) begin
      chk("to rsp_ready", 32'(mem_rsp_ready), 32'd1);
      chk("to early out_valid", 32'(out_valid), 32'd0);
      tick();
    end
    chk("to out_valid", 32'(out_valid), 32'd1);
    chk("to out_fault", 32'(out_fault), 32'd1);
    chk("to out_rdata", out_rdata, 32'd0);
    chk("to in_ready busy", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("drop out_valid", 32'(out_valid), 32'd0);
    chk("drop in_ready", 32'(in_ready), 32'd0);
    chk("drop rsp_ready", 32'(mem_rsp_ready), 32'd1);
    tick();
    chk("drop in_ready hold", 32'(in_ready), 32'd0);
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h1111_2222;
    tick();
    mem_rsp_valid = 1'b0;
    chk("drop done in_ready", 32'(in_ready), 32'd1);
    chk("drop done rsp_ready", 32'(mem_rsp_ready), 32'd0);
    chk("drop no out_valid", 32'(out_valid), 32'd0);

    // Async reset in the middle of a store's RSP phase
    in_valid = 1'b1; in_is_load = 1'b0; in_is_store = 1'b1;
    in_funct3 = 3'b010; in_addr = 32'h8000_0200; in_wdata = 32'h0BAD_CAFE;
    tick();
    in_valid = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    chk("pre-rst rsp_ready", 32'(mem_rsp_ready), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("arst out_valid", 32'(out_valid), 32'd0);
    chk("arst rsp_ready", 32'(mem_rsp_ready), 32'd0);
    chk("arst req_valid", 32'(mem_req_valid), 32'd0);
    chk("arst out_rdata", out_rdata, 32'd0);
    chk("arst req_we", 32'(mem_req_we), 32'd0);
    chk("arst req_addr", mem_req_addr, 32'd0);
    chk("arst req_wmask", 32'(mem_req_wmask), 32'd0);
    chk("arst req_wdata", mem_req_wdata, 32'd0);
    chk("arst in_ready", 32'(in_ready), 32'd1);
    tick();
    reset = 1'b1;
    tick();

    // Randomized ops against the reference model
    for (int n = 0; n < 60; n++) begin
      int kind;
      kind = $urandom_range(0, 2);
      run_op("rand", kind == 1, kind == 2, 3'($urandom), $urandom, $urandom, $urandom,
             $urandom_range(0, 2), $urandom_range(0, TO - 1), $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
